// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and dmem access-size codes.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Same codes the load/store muxes and dmem already use.
    localparam logic [1:0] DSIZE_BYTE = 2'd0;
    localparam logic [1:0] DSIZE_HALF = 2'd1;
    localparam logic [1:0] DSIZE_WORD = 2'd3;

endpackage

// File: rtl/arb_req_mux.sv
// Two-way selection of the requester signals onto the dmem port, gated by the grants.
module arb_req_mux (
    input  logic        cpu_gnt,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_dsize,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        dma_gnt,
    input  logic        dma_we,
    input  logic [1:0]  dma_dsize,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_dsize,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    // CPU signals are the idle default; the write enable is what keeps an idle port harmless.
    always_comb begin
        mem_dsize = dma_gnt ? dma_dsize : cpu_dsize;
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-cycle dmem port between the CPU and a DMA requester, with a starvation
// guard for DMA and bounded locked bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_dsize,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_we,
    input  logic [1:0]  dma_dsize,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [1:0]  mem_dsize,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cpu_stall,
    output logic        dma_burst
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state;
    logic [BW-1:0] beat_cnt;
    logic [SW-1:0] starve_cnt;

    // Grants are forced low while reset is held, not just after it is sampled.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            case (state)
                ST_ARB: begin
                    if (dma_req && (starve_cnt == STARVE_MAX)) begin
                        dma_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                end
                ST_BURST: dma_gnt = dma_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_ARB;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            dma_burst  <= 1'b0;
        end else begin
            if (dma_gnt) begin
                starve_cnt <= '0;
            end else if (dma_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                ST_ARB: begin
                    if (dma_gnt && dma_lock) begin
                        state     <= ST_BURST;
                        beat_cnt  <= BW'(1);
                        dma_burst <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (!dma_req || !dma_lock || ((beat_cnt + 1'b1) == BEAT_MAX)) begin
                        state     <= ST_ARB;
                        beat_cnt  <= '0;
                        dma_burst <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_ARB;
                    beat_cnt  <= '0;
                    dma_burst <= 1'b0;
                end
            endcase
        end
    end

    arb_req_mux u_mux (
        .cpu_gnt   (cpu_gnt),
        .cpu_we    (cpu_we),
        .cpu_dsize (cpu_dsize),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dma_gnt   (dma_gnt),
        .dma_we    (dma_we),
        .dma_dsize (dma_dsize),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .mem_we    (mem_we),
        .mem_dsize (mem_dsize),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked against a
// cycle-level behavioural model of the arbitration rules plus a reference memory image.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_lock, dma_we;
    logic [1:0]  cpu_dsize, dma_dsize;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, mem_we, cpu_stall, dma_burst;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_dsize;

    int vectors = 0;
    int miscompares = 0;

    // dmem stand-in, written by the DUT's port; ref_mem is the image the model expects.
    logic [31:0] dmem_stub [4096];
    logic [31:0] ref_mem   [4096];

    // Behavioural model state.
    bit m_burst;
    int m_beats;
    int m_wait;

    bit obs_cpu [64];
    bit obs_dma [64];
    int obs_n;

    always #5 clock = ~clock;

    assign mem_rdata = dmem_stub[mem_addr[13:2]];
    always @(posedge clock) if (mem_we) dmem_stub[mem_addr[13:2]] <= mem_wdata;

    dmem_arbiter #(
        .MAX_BURST    (MAX_BURST),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_dsize (cpu_dsize),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .dma_we    (dma_we),
        .dma_dsize (dma_dsize),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .mem_we    (mem_we),
        .mem_dsize (mem_dsize),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_stall (cpu_stall),
        .dma_burst (dma_burst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: predict, check mid-cycle, then advance the model at the edge.
    task automatic step();
        bit ec, ed, ewe;
        logic [31:0] ea;
        ec = 0;
        ed = 0;
        if (!reset) begin
            if (m_burst) ed = dma_req;
            else if (dma_req && m_wait >= STARVE_LIMIT) ed = 1;
            else if (cpu_req) ec = 1;
            else if (dma_req) ed = 1;
        end
        ewe = (ec && cpu_we) || (ed && dma_we);
        ea  = ed ? dma_addr : cpu_addr;
        #3;
        check("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        check("dma_gnt", 32'(dma_gnt), 32'(ed));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec));
        check("dma_burst", 32'(dma_burst), 32'(m_burst && !reset));
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ed ? dma_wdata : cpu_wdata);
        check("mem_dsize", 32'(mem_dsize), 32'(ed ? dma_dsize : cpu_dsize));
        if (ec) check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[13:2]]);
        if (ed) check("dma_rdata", dma_rdata, ref_mem[dma_addr[13:2]]);
        if (obs_n < 64) begin
            obs_cpu[obs_n] = cpu_gnt;
            obs_dma[obs_n] = dma_gnt;
            obs_n++;
        end
        @(posedge clock);
        if (reset) begin
            m_burst = 0;
            m_beats = 0;
            m_wait  = 0;
        end else begin
            if (ec && cpu_we) ref_mem[cpu_addr[13:2]] = cpu_wdata;
            if (ed && dma_we) ref_mem[dma_addr[13:2]] = dma_wdata;
            if (ed) m_wait = 0;
            else if (dma_req && m_wait < STARVE_LIMIT) m_wait++;
            if (!m_burst) begin
                if (ed && dma_lock) begin
                    m_burst = 1;
                    m_beats = 1;
                end
            end else if (!dma_req || !dma_lock) begin
                m_burst = 0;
                m_beats = 0;
            end else begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_burst = 0;
                    m_beats = 0;
                end
            end
        end
        #1;
    endtask

    task automatic cpu_set(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_dsize = DSIZE_WORD;
    endtask

    task automatic dma_set(input bit req, input bit lock, input bit we, input logic [31:0] a,
                           input logic [31:0] d);
        dma_req = req;
        dma_lock = lock;
        dma_we = we;
        dma_addr = a;
        dma_wdata = d;
        dma_dsize = DSIZE_WORD;
    endtask

    initial begin
        int first, run;
        for (int i = 0; i < 4096; i++) begin
            dmem_stub[i] = '0;
            ref_mem[i] = '0;
        end
        m_burst = 0;
        m_beats = 0;
        m_wait = 0;
        obs_n = 0;
        reset = 1'b1;
        cpu_set(1, 1, 32'h40, 32'h1234_5678);
        dma_set(1, 0, 1, 32'h80, 32'h5555_AAAA);
        step();
        step();
        reset = 1'b0;

        // CPU-only store then load.
        dma_set(0, 0, 0, 32'h0, 32'h0);
        cpu_set(1, 1, 32'h40, 32'hDEAD_BEEF);
        step();
        cpu_set(1, 0, 32'h40, 32'h0);
        #3;
        check("cpu_readback", cpu_rdata, 32'hDEAD_BEEF);
        #1;
        check("cpu_readback_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clock);
        #1;

        // Contention: DMA forced ahead after STARVE_LIMIT denials.
        obs_n = 0;
        cpu_set(1, 0, 32'h44, 32'h0);
        dma_set(1, 0, 1, 32'h200, 32'hCAFE_0001);
        repeat (6) step();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("contend_dma%0d", i), 32'(obs_dma[i]), 32'(i == 4));
            check($sformatf("contend_cpu%0d", i), 32'(obs_cpu[i]), 32'(i != 4));
        end

        // Burst cap with CPU waiting.
        obs_n = 0;
        dma_set(1, 1, 1, 32'h300, 32'hB0B0_0000);
        repeat (16) step();
        first = -1;
        for (int i = 0; i < 16; i++) if (first < 0 && obs_dma[i]) first = i;
        run = 0;
        if (first >= 0) for (int i = first; i < 16 && obs_dma[i]; i++) run++;
        check("burst_len", 32'(run), 32'(MAX_BURST));
        if (first >= 0 && first + run < 16) check("cpu_after_burst", 32'(obs_cpu[first + run]), 32'd1);

        // Drain pending DMA, then an early-unlock burst of writes.
        cpu_set(0, 0, 32'h0, 32'h0);
        dma_set(0, 0, 0, 32'h0, 32'h0);
        step();
        for (int b = 0; b < 3; b++) begin
            dma_set(1, b < 2, 1, 32'h100 + 32'(4 * b), 32'hA000_0000 + 32'(b));
            step();
        end
        cpu_set(1, 0, 32'h108, 32'h0);
        dma_set(1, 1, 1, 32'h10C, 32'hA000_0003);
        #3;
        check("unlock_cpu_wins", 32'(cpu_gnt), 32'd1);
        check("unlock_read", cpu_rdata, 32'hA000_0002);
        #1;
        @(posedge clock);
        #1;
        m_wait = 1;

        // Reset mid-burst at beat 2.
        cpu_set(0, 0, 32'h0, 32'h0);
        dma_set(1, 1, 1, 32'h400, 32'h1111_2222);
        step();
        dma_set(1, 1, 1, 32'h404, 32'h3333_4444);
        step();
        cpu_set(1, 0, 32'h40, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        dma_set(0, 0, 0, 32'h0, 32'h0);
        step();

        // Idle.
        cpu_set(0, 0, 32'h0, 32'h0);
        repeat (3) step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_dsize = 2'($urandom);
            cpu_addr = {18'b0, 12'($urandom), 2'b00};
            cpu_wdata = $urandom;
            dma_req = ($urandom_range(0, 2) != 0);
            dma_lock = ($urandom_range(0, 3) != 0);
            dma_we = $urandom_range(0, 1) == 1;
            dma_dsize = 2'($urandom);
            dma_addr = {18'b0, 12'($urandom), 2'b00};
            dma_wdata = $urandom;
            obs_n = 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (dmem, SIZE 16384) between the CPU load/store path and a DMA/loader requester.
- Sits between the CPU's ALU-address/store-data/dsize path and dmem.
- CPU has default priority. A starvation guard bounds DMA wait, and DMA may lock the port for bounded bursts.
- Drives a stall to the fetch unit whenever the CPU is denied.

Parameters:
- MAX_BURST, 8, maximum consecutive DMA beats under lock (≥2).
- STARVE_LIMIT, 4, cycles a pending DMA request may be denied before it is forced ahead of the CPU (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  CPU store.
- cpu_dsize  in  2  access size, same encoding as dmem.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_rdata  out  32  load data (valid when cpu_gnt).
- dma_req  in  1  DMA access request.
- dma_lock  in  1  request to keep ownership for following beats.
- dma_we  in  1  DMA write.
- dma_dsize  in  2  access size.
- dma_addr  in  32  byte address.
- dma_wdata  in  32  write data.
- dma_gnt  out  1  DMA beat performed this cycle.
- dma_rdata  out  32  read data (valid when dma_gnt).
- mem_we  out  1  to dmem write enable.
- mem_dsize  out  2  to dmem.
- mem_addr  out  32  to dmem.
- mem_wdata  out  32  to dmem.
- mem_rdata  in  32  from dmem (combinational read).
- cpu_stall  out  1  to IFU: cpu_req & ~cpu_gnt; holds PC and suppresses regwrite.
- dma_burst  out  1  high while in BURST state.

Behaviour:
- Grants are combinational from the registered state plus current requests. State and counters update on the rising clock edge.
- Reset (asynchronous) drives state to ARB, beat_cnt=0, starve_cnt=0, dma_burst=0. Outputs during reset:
  - cpu_gnt=dma_gnt=0, mem_we=0.
  - cpu_stall = cpu_req.
- States: ARB, BURST.
- ARB grant rules, in priority order:
  - If dma_req and starve_cnt==STARVE_LIMIT, grant DMA.
  - Else if cpu_req, grant CPU.
  - Else if dma_req, grant DMA.
  - Else no grant.
- ARB transitions: a DMA grant with dma_lock=1 goes to BURST with beat_cnt=1. Otherwise the state stays ARB.
- BURST grant rule: dma_gnt = dma_req and cpu_gnt = 0, even if cpu_req is high.
- BURST beat counting: each granted beat increments beat_cnt.
- BURST exits to ARB at the end of the cycle when any of these holds, and beat_cnt resets to 0:
  - dma_req=0;
  - dma_lock=0 (that beat is still granted);
  - the granted beat makes beat_cnt==MAX_BURST.
- After a MAX_BURST exit, ARB applies normal rules, so a waiting CPU wins the next cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on cycles with dma_req & ~dma_gnt.
  - Clears on any dma_gnt.
  - Holds when dma_req=0.
- Port mux:
  - mem_* carry the granted requester's signals.
  - With no grant, mem_addr/mem_wdata/mem_dsize carry the CPU signals and mem_we=0.
  - mem_we = granted requester's we and never 1 without a grant.
- Data return: cpu_rdata = dma_rdata = mem_rdata (broadcast). Each is meaningful only with its own gnt.
- Latency: zero-cycle. A granted access completes in the grant cycle, matching single-cycle dmem timing.
- Simultaneous cpu_req and dma_req in ARB with starve_cnt<STARVE_LIMIT: the CPU wins and starve_cnt increments.
- Reset asserted mid-burst: the burst is abandoned immediately and no partial-state recovery is performed.
- dsize/addr alignment is not checked here; dmem handles it.

Decomposition:
- Shared package/header holds:
  - state encodings ST_ARB=1'b0, ST_BURST=1'b1;
  - dsize encoding constants (byte=0, half=1, word=3, matching the existing load/store muxes).
- Sub-module arb_req_mux: the combinational 2-way selection of addr/wdata/we/dsize, gated by grant.
- FSM and counters stay in dmem_arbiter. Counter widths are $clog2(MAX_BURST+1) and $clog2(STARVE_LIMIT+1).

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr=0x40, wdata=0xDEADBEEF, dsize=3 → cpu_gnt=1, mem_we=1, cpu_stall=0. A following read of 0x40 returns cpu_rdata=0xDEADBEEF.
- Contention and starvation: cpu_req and dma_req (unlocked) held high with STARVE_LIMIT=4 → CPU granted cycles 0-3, DMA granted cycle 4 with cpu_stall=1, CPU granted cycle 5.
- Burst cap: dma_req=dma_lock=1 continuously, cpu_req=1, MAX_BURST=8 → 8 consecutive dma_gnt with dma_burst=1, then cpu_gnt=1 on the 9th cycle.
- Early unlock: burst of dma writes to 0x100..0x10C with dma_lock dropped on beat 3 → beat 3 granted, next cycle ARB, CPU wins if requesting.
- Reset mid-burst: assert reset at beat 2 → dma_gnt=0, dma_burst=0, mem_we=0 immediately. After release with dma_req=0 and cpu_req=1, cpu_gnt=1 on the first edge.
- Idle: no requests → mem_we=0, both gnt=0, starve_cnt stays 0.
